zbuf_arbiter: RTL and testbench

- Sequences and shares the single-port z-buffer SRAM between two requesters: port A (colorfill depth read/write) and port B (readback/debug).
- Also contains a clear engine that fills the whole buffer with CLEAR_VAL on each frame start.
- Sits between colorfill, the readback logic and zbuffer_sram, and is the only driver of the SRAM control pins.

---
 rtl/zbuf_arbiter.sv | 169 ++++++++++++++++
 tb/tb_zbuf_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zbuf_arbiter.sv
// -----------------------------------------------------------------------------
// zbuf_arbiter
//   Shares the single-port z-buffer SRAM between the colorfill depth port (A)
//   and the readback/debug port (B), and owns a clear engine that floods the
//   whole buffer with CLEAR_VAL at every frame start. This block is the only
//   driver of the SRAM control pins.
//
// Ports
//   clk, n_rst                 clock (rising edge), async active-low reset
//   frame_start                one-cycle pulse: (re)start a full buffer clear
//   clear_busy / clear_done    clear engine owns SRAM / pulse after last write
//   a_req/a_we/a_addr/a_wdata  port A request (held until granted)
//   a_gnt / a_rvalid           port A grant (combinational) / read data valid
//   b_req/b_we/b_addr/b_wdata  port B request, same meaning as port A
//   b_gnt / b_rvalid           port B grant / read data valid
//   rdata                      shared read data (straight from sram_rdata)
//   sram_en/we/addr/wdata      SRAM access controls
//   sram_rdata                 SRAM read data, one cycle after a read access
// -----------------------------------------------------------------------------
module zbuf_arbiter #(
  parameter int                 DEPTH     = 76800,
  parameter int                 ADDR_W    = 17,
  parameter int                 DATA_W    = 16,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              frame_start,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Pointer holds the port granted last; the other port wins the next tie.
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic              clear_busy_q, clear_busy_d;
  logic              clear_done_q, clear_done_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic              a_gnt_c, b_gnt_c;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= SERVE;
      cnt_q        <= '0;
      ptr_q        <= PTR_B;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    clear_busy_d = clear_busy_q;
    clear_done_d = 1'b0;
    a_gnt_c      = 1'b0;
    b_gnt_c      = 1'b0;
    sram_en      = 1'b0;
    sram_we      = 1'b0;
    sram_addr    = '0;
    sram_wdata   = '0;

    case (state_q)
      SERVE: begin
        if (frame_start) begin
          // The clear takes the SRAM from the next cycle; nobody is granted now.
          state_d      = CLEAR;
          cnt_d        = '0;
          clear_busy_d = 1'b1;
        end else begin
          if (a_req && (!b_req || (ptr_q == PTR_B))) begin
            a_gnt_c = 1'b1;
          end else if (b_req) begin
            b_gnt_c = 1'b1;
          end

          if (a_gnt_c) begin
            ptr_d      = PTR_A;
            sram_en    = 1'b1;
            sram_we    = a_we;
            sram_addr  = a_addr;
            sram_wdata = a_wdata;
          end else if (b_gnt_c) begin
            ptr_d      = PTR_B;
            sram_en    = 1'b1;
            sram_we    = b_we;
            sram_addr  = b_addr;
            sram_wdata = b_wdata;
          end
        end
      end

      CLEAR: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = cnt_q;
        sram_wdata = CLEAR_VAL;
        if (frame_start) begin
          // A new frame restarts the sweep, even on its final word.
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d      = SERVE;
          cnt_d        = '0;
          clear_busy_d = 1'b0;
          clear_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = SERVE;
      end
    endcase

    a_rvalid_d = a_gnt_c && !a_we;
    b_rvalid_d = b_gnt_c && !b_we;
  end

  assign a_gnt      = a_gnt_c;
  assign b_gnt      = b_gnt_c;
  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;
  assign rdata      = sram_rdata;

endmodule

// File: tb/tb_zbuf_arbiter.sv
// -----------------------------------------------------------------------------
// tb_zbuf_arbiter
//   Directed bench for zbuf_arbiter with a small behavioural SRAM. Read
//   expectations go into a queue when a read is expected to be granted and are
//   popped when rvalid appears on either port.
// -----------------------------------------------------------------------------
module tb_zbuf_arbiter;

  localparam int          DEPTH  = 16;
  localparam int          ADDR_W = 5;
  localparam int          DATA_W = 16;
  localparam logic [15:0] CV     = 16'hFFFF;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              frame_start;
  logic              clear_busy, clear_done;
  logic              a_req, a_we, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              b_req, b_we, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] rdata;
  logic              sram_en, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  zbuf_arbiter #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .CLEAR_VAL (CV)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .frame_start (frame_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_gnt       (a_gnt),
    .a_rvalid    (a_rvalid),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_gnt       (b_gnt),
    .b_rvalid    (b_rvalid),
    .rdata       (rdata),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM, preloaded with 0x1000+addr.
  logic [DATA_W-1:0] mem [0:31];
  logic              loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h1000 + 16'(i);
      loaded <= 1'b1;
    end else if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  typedef struct {
    logic        port;   // 0 = A, 1 = B
    logic [15:0] data;
  } rd_t;

  rd_t q[$];
  int  n_cmp    = 0;
  int  n_err    = 0;
  int  done_cnt = 0;
  int  d0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic [15:0] d);
    rd_t e;
    e.port = port;
    e.data = d;
    q.push_back(e);
  endtask

  // Read-return scoreboard and clear_done counter, evaluated mid-cycle.
  task automatic monitor();
    rd_t e;
    if (clear_done) done_cnt++;
    if (a_rvalid || b_rvalid) begin
      chk("rv_excl", {31'd0, a_rvalid & b_rvalid}, 32'd0);
      n_cmp++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL rv_unexpected observed=a%0b/b%0b expected=no rvalid", a_rvalid, b_rvalid);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rv_port", {31'd0, b_rvalid}, {31'd0, e.port});
        chk("rv_data", {16'd0, rdata}, {16'd0, e.data});
        chk("rdata_pass", {16'd0, rdata}, {16'd0, sram_rdata});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_a;
    n_rst = 0; frame_start = 0;
    idle();
    repeat (3) tick();

    // Reset state
    chk("rst_busy",   clear_busy, 0);
    chk("rst_done",   clear_done, 0);
    chk("rst_arv",    a_rvalid,   0);
    chk("rst_brv",    b_rvalid,   0);
    chk("rst_en",     sram_en,    0);
    chk("rst_we",     sram_we,    0);
    n_rst = 1;

    // Both ports requesting: A wins first, then strict alternation
    a_req = 1; a_addr = 3; b_req = 1; b_addr = 4;
    for (int k = 0; k < 4; k++) begin
      settle();
      exp_a = (k % 2 == 0);
      chk("tie_a_gnt", a_gnt, exp_a);
      chk("tie_b_gnt", b_gnt, !exp_a);
      chk("tie_excl",  a_gnt & b_gnt, 0);
      chk("tie_addr",  sram_addr, exp_a ? 3 : 4);
      push(!exp_a, exp_a ? 16'h1003 : 16'h1004);
      tick();
    end
    idle();
    settle();
    chk("idle_en", sram_en, 0);
    chk("idle_we", sram_we, 0);
    tick();

    // Fresh reset, single A read of addr 5
    n_rst = 0;
    tick();
    n_rst = 1;
    a_req = 1; a_we = 0; a_addr = 5;
    settle();
    chk("rd5_a_gnt", a_gnt, 1);
    chk("rd5_b_gnt", b_gnt, 0);
    chk("rd5_en",    sram_en, 1);
    chk("rd5_we",    sram_we, 0);
    chk("rd5_addr",  sram_addr, 5);
    push(0, 16'h1005);
    tick();
    idle();
    settle();
    chk("rd5_rvalid", a_rvalid, 1);
    chk("rd5_rdata",  rdata, 16'h1005);
    tick();
    chk("rd5_rv_low", a_rvalid, 0);

    // Writes on both ports, then a B read-back
    a_req = 1; a_we = 1; a_addr = 7; a_wdata = 16'hA5A5;
    settle();
    chk("wa_gnt",   a_gnt, 1);
    chk("wa_we",    sram_we, 1);
    chk("wa_wdata", sram_wdata, 16'hA5A5);
    tick();
    idle();
    b_req = 1; b_we = 1; b_addr = 12; b_wdata = 16'h5A5A;
    settle();
    chk("wa_no_rv", a_rvalid, 0);
    chk("wb_gnt",   b_gnt, 1);
    chk("wb_addr",  sram_addr, 12);
    tick();
    b_we = 0;
    settle();
    chk("wb_no_rv", b_rvalid, 0);
    chk("rb_gnt",   b_gnt, 1);
    push(1, 16'h5A5A);
    tick();
    idle();
    settle();
    chk("rb_rvalid", b_rvalid, 1);
    tick();

    // frame_start with A request pending: A stalls through the full clear
    d0 = done_cnt;
    frame_start = 1; a_req = 1; a_we = 0; a_addr = 5;
    settle();
    chk("fs_a_gnt", a_gnt, 0);
    chk("fs_en",    sram_en, 0);
    tick();
    frame_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      chk("clr_busy",  clear_busy, 1);
      chk("clr_we",    {31'd0, sram_en & sram_we}, 1);
      chk("clr_addr",  sram_addr, i);
      chk("clr_wdata", sram_wdata, CV);
      chk("clr_a_gnt", a_gnt, 0);
      chk("clr_done",  clear_done, 0);
      tick();
    end
    settle();
    chk("end_done",  clear_done, 1);
    chk("end_busy",  clear_busy, 0);
    chk("end_a_gnt", a_gnt, 1);
    chk("end_addr",  sram_addr, 5);
    push(0, CV);
    tick();
    idle();
    settle();
    chk("end_rvalid",   a_rvalid, 1);
    chk("end_done_low", clear_done, 0);
    chk("end_done_cnt", done_cnt - d0, 1);

    // Restart at clear address 7
    d0 = done_cnt;
    frame_start = 1;
    tick();
    frame_start = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("rs_addr1", sram_addr, i);
      if (i == 7) frame_start = 1;
      tick();
      frame_start = 0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      chk("rs_addr2", sram_addr, i);
      chk("rs_busy",  clear_busy, 1);
      chk("rs_done",  clear_done, 0);
      tick();
    end
    settle();
    chk("rs_end_done", clear_done, 1);
    tick();
    tick();
    chk("rs_done_cnt", done_cnt - d0, 1);

    // Restart on the final clear word: no clear_done, sweep restarts at 0
    d0 = done_cnt;
    frame_start = 1;
    tick();
    frame_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      chk("fl_addr", sram_addr, i);
      if (i == DEPTH - 1) frame_start = 1;
      tick();
      frame_start = 0;
    end
    settle();
    chk("fl_busy", clear_busy, 1);
    chk("fl_done", clear_done, 0);
    chk("fl_addr0", sram_addr, 0);
    tick();
    for (int i = 1; i < DEPTH; i++) begin
      settle();
      chk("fl_addr2", sram_addr, i);
      tick();
    end
    settle();
    chk("fl_end_done", clear_done, 1);
    tick();
    chk("fl_done_cnt", done_cnt - d0, 1);

    // Seed addr 3 and 12, then reset in the middle of a clear at addr 9
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 16'h5555;
    tick();
    idle();
    b_req = 1; b_we = 1; b_addr = 12; b_wdata = 16'h5555;
    tick();
    idle();
    d0 = done_cnt;
    frame_start = 1;
    tick();
    frame_start = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("rc_addr", sram_addr, i);
      if (i < 9) tick();
    end
    n_rst = 0;
    #1;
    chk("rc_busy", clear_busy, 0);
    chk("rc_en",   sram_en, 0);
    chk("rc_done", clear_done, 0);
    tick();
    n_rst = 1;
    a_req = 1; a_we = 0; a_addr = 3;
    settle();
    chk("rc_a_gnt", a_gnt, 1);
    chk("rc_addr3", sram_addr, 3);
    push(0, CV);
    tick();
    idle();
    b_req = 1; b_we = 0; b_addr = 12;
    settle();
    chk("rc_b_gnt", b_gnt, 1);
    push(1, 16'h5555);
    tick();
    idle();
    repeat (3) tick();
    chk("rc_done_cnt", done_cnt - d0, 0);
    chk("sb_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
